// File: rtl/issue_sb_pkg.sv
// Shared types and helpers for the issue scoreboard slice.
// Entry states are exported so the top can derive the debug busy vector from them.
package issue_sb_pkg;

   localparam int NUM_REGS_DEF = 32;
   localparam int RW           = $clog2(NUM_REGS_DEF);
   localparam int LAT_W_DEF    = 3;

   typedef logic [RW-1:0]        reg_idx_t;
   typedef logic [LAT_W_DEF-1:0] lat_t;

   // TIMED counts itself down; VAR waits for a write-back.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TIMED = 2'd1,
      ST_VAR   = 2'd2
   } entry_state_t;

   // Register 0 is hardwired zero and never creates a dependency.
   function automatic logic src_needs_check(input int unsigned idx);
      return idx != 0;
   endfunction

endpackage

// File: rtl/sb_reg_entry.sv
// Busy/countdown tracker for one architectural register (flush > set > countdown/clear).
// SCOREBOARD_BYPASS_EN lets a same-cycle write-back count as ready/free.
module sb_reg_entry
   import issue_sb_pkg::*;
#(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             set,
   input  logic [LAT_W-1:0] set_lat,
   input  logic             wb_clr,
   output entry_state_t     state,
   output logic             ready,
   output logic             free
);

   logic [LAT_W-1:0] cnt;
   logic             busy;
   logic             last_cycle;

   assign busy       = (state != ST_IDLE);
   assign last_cycle = (state == ST_TIMED) && (cnt == LAT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (set) begin
         // A new producer wins over any clear landing in the same cycle.
         state <= (set_lat == '0) ? ST_VAR : ST_TIMED;
         cnt   <= set_lat;
      end else begin
         case (state)
            ST_TIMED: begin
               if (wb_clr || last_cycle) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - LAT_W'(1);
               end
            end
            ST_VAR: begin
               if (wb_clr) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef SCOREBOARD_BYPASS_EN
   assign ready = !busy || last_cycle || wb_clr;
   assign free  = !busy || wb_clr;
`else
   assign ready = !busy || last_cycle;
   assign free  = !busy;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// In-order N-wide issue scoreboard: grants the longest hazard-free prefix of the bundle.
// Optional SCOREBOARD_BYPASS_EN forwards same-cycle write-backs to the ready check.
module issue_scoreboard
   import issue_sb_pkg::*;
#(
   parameter int ISSUE_W  = 2,
   parameter int WB_PORTS = 2,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int LAT_W    = LAT_W_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic [ISSUE_W-1:0]                    issue_valid,
   input  logic [ISSUE_W*$clog2(NUM_REGS)-1:0]   issue_dest,
   input  logic [ISSUE_W*$clog2(NUM_REGS)-1:0]   issue_src1,
   input  logic [ISSUE_W*$clog2(NUM_REGS)-1:0]   issue_src2,
   input  logic [ISSUE_W-1:0]                    issue_wen,
   input  logic [ISSUE_W*LAT_W-1:0]              issue_lat,
   input  logic [WB_PORTS-1:0]                   wb_valid,
   input  logic [WB_PORTS*$clog2(NUM_REGS)-1:0]  wb_dest,
   output logic [ISSUE_W-1:0]                    issue_grant,
   output logic                                  stall,
   output logic [NUM_REGS-1:0]                   busy_vec
);

   localparam int RIDX_W = $clog2(NUM_REGS);

   logic [NUM_REGS-1:0] ready_vec;
   logic [NUM_REGS-1:0] free_vec;
   logic [NUM_REGS-1:1] set_vec;
   logic [NUM_REGS-1:1] clr_vec;
   logic [LAT_W-1:0]    set_lat [1:NUM_REGS-1];
   entry_state_t        st      [NUM_REGS];
   logic [ISSUE_W-1:0]  grant_c;

   assign ready_vec[0] = 1'b1;
   assign free_vec[0]  = 1'b1;
   assign st[0]        = ST_IDLE;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      sb_reg_entry #(.LAT_W(LAT_W)) u_entry (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .set     (set_vec[r]),
         .set_lat (set_lat[r]),
         .wb_clr  (clr_vec[r]),
         .state   (st[r]),
         .ready   (ready_vec[r]),
         .free    (free_vec[r])
      );
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_vec[r] = (st[r] != ST_IDLE);
      end
   end

   always_comb begin
      clr_vec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_dest[p*RIDX_W +: RIDX_W] == RIDX_W'(r))) begin
               clr_vec[r] = 1'b1;
            end
         end
      end
   end

   logic [RIDX_W-1:0] d_k, s1_k, s2_k, d_j;
   logic              elig, prefix;

   always_comb begin
      grant_c = '0;
      prefix  = 1'b1;
      d_k     = '0;
      s1_k    = '0;
      s2_k    = '0;
      d_j     = '0;
      elig    = 1'b0;
      for (int k = 0; k < ISSUE_W; k++) begin
         d_k  = issue_dest[k*RIDX_W +: RIDX_W];
         s1_k = issue_src1[k*RIDX_W +: RIDX_W];
         s2_k = issue_src2[k*RIDX_W +: RIDX_W];
         elig = issue_valid[k];
         if (src_needs_check(32'(s1_k)) && !ready_vec[s1_k]) elig = 1'b0;
         if (src_needs_check(32'(s2_k)) && !ready_vec[s2_k]) elig = 1'b0;
         if (issue_wen[k] && src_needs_check(32'(d_k)) && !free_vec[d_k]) elig = 1'b0;
         // Earlier slots must all be granted for slot k to be, so checking them all is exact.
         for (int j = 0; j < k; j++) begin
            d_j = issue_dest[j*RIDX_W +: RIDX_W];
            if (issue_valid[j] && issue_wen[j] && src_needs_check(32'(d_j))) begin
               if ((d_j == s1_k) || (d_j == s2_k)) elig = 1'b0;
               if (issue_wen[k] && (d_j == d_k))   elig = 1'b0;
            end
         end
         prefix     = prefix & elig;
         grant_c[k] = prefix;
      end
      if (rst) grant_c = '0;
   end

   // At most one granted slot can name a register, so OR-merging the latency is safe.
   always_comb begin
      set_vec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         set_lat[r] = '0;
         for (int k = 0; k < ISSUE_W; k++) begin
            if (grant_c[k] && issue_wen[k] &&
                (issue_dest[k*RIDX_W +: RIDX_W] == RIDX_W'(r))) begin
               set_vec[r] = 1'b1;
               set_lat[r] = set_lat[r] | issue_lat[k*LAT_W +: LAT_W];
            end
         end
      end
   end

   assign issue_grant = grant_c;
   assign stall       = issue_valid[0] & ~grant_c[0];

endmodule
